uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the floating-point ALU host link. Supports configurable data width, optional parity, one or two stop bits, oversampled reception with 3-sample majority voting, and reports parity errors, framing errors and line breaks. It sits between the board RX pin and the command/operand deframer, and delivers one-cycle valid strobes with qualifying error flags.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, sample ticks per bit; even, minimum 8

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  last received word, LSB received first
rx_valid  out  1  one-cycle strobe: frame complete, rx_data updated
parity_err  out  1  parity mismatch; valid only while rx_valid=1
frame_err  out  1  a stop bit sampled 0; valid only while rx_valid=1
break_det  out  1  break frame detected; valid only while rx_valid=1
busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (async assert, sync release): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, break_det=0, busy=0, FSM=IDLE, both synchroniser flops=1. Reset mid-frame abandons the frame and produces no strobe.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Tick divider DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), floor, minimum 1. The divider is cleared on start detection, giving one tick every DIV clocks while busy.
- Bit sample = majority of synchronised rx at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit. The bit ends at tick OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE -> START on a synchronised 1->0 edge; busy=1.
- START: if the majority sample is 1, this is a false start; return to IDLE after the sample with no strobe. Otherwise go to DATA at end of bit.
- DATA: shift in DATA_BITS samples, LSB first. Then go to PARITY if PARITY!=0, else STOP.
- PARITY: expected bit is XOR of the data bits (even) or its inverse (odd); a mismatch sets the internal perr.
- STOP: sample STOP_BITS stop bits. At the mid-sample of the final stop bit the frame completes; do not wait for the end of the bit.
- Frame completion, in the next clk cycle:
  - rx_valid=1 for exactly one cycle.
  - rx_data is loaded.
  - parity_err=perr; frame_err=1 if any stop sample was 0.
  - break_det=1 if all data, parity and stop samples were 0 (this implies frame_err=1).
  - All flags are 0 in every other cycle.
- After completion: if frame_err=0, go to IDLE (busy=0), ready for a start edge in the following cycle. If frame_err=1, go to WAIT_HIGH.
- WAIT_HIGH: stay until synchronised rx has been high for one full bit (OVERSAMPLE ticks), then go to IDLE. A break of any length yields exactly one strobe.
- Error frames still deliver rx_data; consumers use the flags to qualify it.
- No backpressure: a new frame overwrites rx_data. rx_valid cannot occur on consecutive frames closer than one frame time.

Test Plan:
Bench configuration unless noted: CLOCK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16 (DIV=1, 16 clk per bit).
1. 8N1, send 0xA5 -> exactly one rx_valid pulse; rx_data=0xA5; all error flags 0; busy=0 within 10 clk of the strobe.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2. Send 0x03 with parity bit 0 -> rx_data=0x03, parity_err=0. Resend 0x03 with parity bit 1 -> parity_err=1 with rx_valid.
3. Glitch: rx low for 4 clk, then high -> no rx_valid; busy returns to 0 by clk 12 after the edge.
4. Majority vote: send 0xFF with a 1-clk low pulse at the middle sample of bit 2 -> rx_data=0xFF, no errors.
5. Frame and break:
   - Send 0x55 with stop bit 0 -> frame_err=1, rx_data=0x55.
   - Hold rx low for 20 bit times -> exactly one strobe with break_det=1, frame_err=1, rx_data=0x00.
   - Release rx high for 1 bit, then send 0x3C -> clean reception.
6. Reset: pull rst_n low during data bit 3 of a frame -> all outputs 0 immediately, busy=0, no strobe. After release, send 0x81 -> rx_data=0x81, no errors.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver.
// Configurable data width, optional odd/even parity and one or two stop bits.
// Each bit is decided by a 3-sample majority vote around mid-bit. A completed
// frame gives a one-cycle rx_valid strobe with parity, framing and break flags.
module uart_rx_cfg #(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_WAIT_HIGH = 3'd5;

   logic                 r_rx_meta;
   logic                 r_rx_sync;
   logic                 r_rx_prev;
   logic [2:0]           r_state;
   logic [DIV_W-1:0]     r_div_cnt;
   logic [TICK_W-1:0]    r_tick_cnt;
   logic [3:0]           r_bit_cnt;
   logic                 r_s0;
   logic                 r_s1;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_all_zero;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_break_det;

   logic w_start_edge;
   logic w_tick;
   logic w_maj;
   logic w_par_exp;
   logic w_frame_bad;
   logic w_break;

   assign w_start_edge = r_rx_prev & ~r_rx_sync;
   assign w_tick       = (r_div_cnt == DIV_LAST);
   // Third vote is the live synchronised value at tick OVERSAMPLE/2+1.
   assign w_maj        = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
   assign w_par_exp    = (PARITY == 1) ? ~r_par : r_par;
   assign w_frame_bad  = r_ferr | ~w_maj;
   assign w_break      = r_all_zero & ~w_maj;

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign break_det  = r_break_det;
   assign busy       = (r_state != S_IDLE);

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   // NOTE: these reset to 1 (idle line) so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Tick divider: held clear while idle so the start edge restarts the phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
      end else if (r_state == S_IDLE || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // Receive FSM, bit sampling, error accumulation and output strobes.
   // NOTE: all state here uses non-blocking assignments; a later assignment in
   // the same branch (e.g. the tick counter on frame completion) overrides an earlier one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_s0         <= 1'b1;
         r_s1         <= 1'b1;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_all_zero   <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_break_det  <= 1'b0;
      end else begin
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_break_det  <= 1'b0;

         if (r_state == S_IDLE) begin
            if (w_start_edge) begin
               // The detection cycle itself counts as tick 0 of the start bit.
               r_state    <= S_START;
               r_tick_cnt <= TICK_W'(1);
               r_bit_cnt  <= '0;
               r_par      <= 1'b0;
               r_perr     <= 1'b0;
               r_ferr     <= 1'b0;
               r_all_zero <= 1'b1;
            end
         end else if (r_state == S_WAIT_HIGH) begin
            if (w_tick) begin
               if (!r_rx_sync) begin
                  r_tick_cnt <= '0;
               end else if (r_tick_cnt == TICK_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_tick_cnt <= r_tick_cnt + TICK_W'(1);
               end
            end
         end else if (w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
               r_tick_cnt <= '0;
            end else begin
               r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end

            if (r_tick_cnt == TICK_S0) begin
               r_s0 <= r_rx_sync;
            end
            if (r_tick_cnt == TICK_S1) begin
               r_s1 <= r_rx_sync;
            end

            if (r_tick_cnt == TICK_S2) begin
               case (r_state)
                  S_START: begin
                     if (w_maj) begin
                        r_state <= S_IDLE;
                     end
                  end
                  S_DATA: begin
                     r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
                     r_par      <= r_par ^ w_maj;
                     r_all_zero <= r_all_zero & ~w_maj;
                  end
                  S_PARITY: begin
                     r_perr     <= (w_maj != w_par_exp);
                     r_all_zero <= r_all_zero & ~w_maj;
                  end
                  S_STOP: begin
                     r_ferr     <= w_frame_bad;
                     r_all_zero <= w_break;
                     if (r_bit_cnt == STOP_LAST) begin
                        // Frame completes at the final stop mid-sample.
                        r_rx_valid   <= 1'b1;
                        r_rx_data    <= r_shift;
                        r_parity_err <= r_perr;
                        r_frame_err  <= w_frame_bad;
                        r_break_det  <= w_break;
                        r_tick_cnt   <= '0;
                        r_state      <= w_frame_bad ? S_WAIT_HIGH : S_IDLE;
                     end
                  end
                  default: begin
                  end
               endcase
            end

            if (r_tick_cnt == TICK_LAST) begin
               case (r_state)
                  S_START: begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= '0;
                  end
                  S_DATA: begin
                     if (r_bit_cnt == DATA_LAST) begin
                        r_bit_cnt <= '0;
                        r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
                  S_PARITY: begin
                     r_bit_cnt <= '0;
                     r_state   <= S_STOP;
                  end
                  S_STOP: begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

endmodule
